instr_prefetch_buffer: RTL

Instruction fetch front end placed directly upstream of the single-cycle RISC_V_Processor datapath. It replaces the combinational Instruction_Memory lookup.
- Issues in-order word requests to a variable-latency instruction memory.
- Buffers returned instructions with their PCs in a small FIFO.
- Presents them to the decode/execute stage over a valid/ready handshake.
- A redirect input, driven by the branch/PCSrc decision, flushes the buffer and restarts fetch.

---
 rtl/instr_prefetch_buffer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instr_prefetch_buffer.sv
// In-order instruction prefetch FIFO with credit-limited requests and redirect flush.
// Optional perf counters (stall_cycles, flush_count) under IPB_PERF_CNT_EN.
module instr_prefetch_buffer #(
   parameter int unsigned    DEPTH    = 4,
   parameter int unsigned    PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [PC_W-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst_data,
   output logic [PC_W-1:0] inst_pc,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc
`ifdef IPB_PERF_CNT_EN
   ,output logic [31:0]    stall_cycles
   ,output logic [15:0]    flush_count
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]     r_mem_data [DEPTH];
   logic [PC_W-1:0] r_mem_pc   [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   r_inflight;
   logic [CW-1:0]   r_drop_cnt;
   logic [PC_W-1:0] r_fetch_pc;
   logic [PC_W-1:0] r_rsp_pc;

   logic [CW:0]     w_occ;
   logic            w_req_fire;
   logic            w_rsp;
   logic            w_drop;
   logic            w_push;
   logic            w_pop;
   logic [PC_W-1:0] w_redir_pc;

   // Buffered plus in-flight slots bound outstanding work, so a push never overflows.
   assign w_occ          = {1'b0, r_count} + {1'b0, r_inflight};
   assign imem_req_valid = reset && (w_occ < (CW+1)'(DEPTH)) && !redirect_valid;
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;
   assign w_rsp          = imem_rsp_valid && (r_inflight != '0);
   assign w_drop         = w_rsp && (r_drop_cnt != '0);
   assign w_push         = w_rsp && !w_drop;
   assign w_pop          = inst_valid && inst_ready;
   assign w_redir_pc     = redirect_pc & ~PC_W'(3);

   assign inst_valid = (r_count != '0);
   assign inst_data  = r_mem_data[r_rd_ptr];
   assign inst_pc    = r_mem_pc[r_rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem_data[i] <= '0;
            r_mem_pc[i]   <= '0;
         end
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= '0;
         r_drop_cnt <= '0;
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
      end else if (redirect_valid) begin
         // Everything still outstanding belongs to the old path and is dropped.
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= r_inflight - CW'(w_rsp);
         r_drop_cnt <= r_inflight - CW'(w_rsp);
         r_fetch_pc <= w_redir_pc;
         r_rsp_pc   <= w_redir_pc;
      end else begin
         if (w_req_fire)
            r_fetch_pc <= r_fetch_pc + PC_W'(4);
         r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp);
         if (w_drop)
            r_drop_cnt <= r_drop_cnt - CW'(1);
         if (w_push) begin
            r_mem_data[r_wr_ptr] <= imem_rsp_data;
            r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
            r_wr_ptr             <= r_wr_ptr + AW'(1);
            r_rsp_pc             <= r_rsp_pc + PC_W'(4);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

`ifdef IPB_PERF_CNT_EN
   logic [31:0] r_stall_cycles;
   logic [15:0] r_flush_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (inst_ready && !inst_valid && !redirect_valid && !(&r_stall_cycles))
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (redirect_valid && !(&r_flush_count))
            r_flush_count <= r_flush_count + 16'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`endif

endmodule
